// File: rtl/mod_n_counter.sv
// Modulo-N up/down counter with clear, parallel load and a zero-latency cascade output.
// Two instances chained through tc form the VGA horizontal/vertical timing counters.
module mod_n_counter #(
  parameter int unsigned WIDTH     = 12,
  parameter int unsigned MODULUS   = 800,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH) || RESET_VAL >= MODULUS)
  begin : gen_param_check
    $error("mod_n_counter: illegal WIDTH/MODULUS/RESET_VAL combination");
  end

  // Modulus held one bit wider so MODULUS == 2**WIDTH is still representable.
  localparam logic [WIDTH:0]   ModExt = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MaxCnt = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic [WIDTH:0]   cnt_inc, cnt_dec;
  logic             at_max, at_zero;

  assign at_max  = (count_q == MaxCnt);
  assign at_zero = (count_q == '0);
  assign cnt_inc = {1'b0, count_q} + (WIDTH+1)'(1);
  assign cnt_dec = {1'b0, count_q} - (WIDTH+1)'(1);

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    err_d   = err_q;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      if ({1'b0, load_val} < ModExt) begin
        count_d = load_val;
      end else begin
        count_d = MaxCnt;
        err_d   = 1'b1;
      end
    end else if (en) begin
      if (up_dn) begin
        if (at_max) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = WIDTH'(cnt_inc);
        end
      end else begin
        if (at_zero) begin
          count_d = MaxCnt;
          wrap_d  = 1'b1;
        end else begin
          count_d = WIDTH'(cnt_dec);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= WIDTH'(RESET_VAL);
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  // tc ignores clr/load so a downstream stage sees the cascade with no added latency.
  assign tc       = en & (up_dn ? at_max : at_zero);
  assign count    = count_q;
  assign wrap     = wrap_q;
  assign load_err = err_q;

endmodule

// File: doc/mod_n_counter.md
Name: mod_n_counter

Overview:
Parametrised modulo-N up/down counter. Next generation of the VGA-path n-bit counter. Adds programmable modulus, direction, enable, synchronous clear, parallel load, terminal-count and cascade outputs. Two instances, horizontal feeding vertical via tc, form the VGA h/v timing counters (800 x 525 for 640x480@60).

Parameters:
WIDTH, 12, counter width in bits; must satisfy 2**WIDTH >= MODULUS.
MODULUS, 800, count range 0..MODULUS-1; legal range 2..2**WIDTH.
RESET_VAL, 0, value loaded on async reset; must be < MODULUS.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
en  in  1  count enable; also the cascade input from a lower stage's tc
clr  in  1  synchronous clear to 0
up_dn  in  1  direction: 1 = up, 0 = down
load  in  1  synchronous parallel load strobe
load_val  in  WIDTH  value to load
count  out  WIDTH  current count (registered)
tc  out  1  terminal count, combinational
wrap  out  1  registered one-cycle pulse after a wrap
load_err  out  1  sticky flag: an out-of-range load was attempted

Behaviour:
- Reset: rst_n low asynchronously forces count=RESET_VAL, wrap=0, load_err=0. Release is synchronous to clk. No other reset path.
- Per-edge priority: clr > load > en > hold.
- clr=1: count<=0; wrap<=0. load_err is unchanged.
- load=1, clr=0:
  - load_val < MODULUS: count<=load_val.
  - load_val >= MODULUS: count<=MODULUS-1 (saturate) and load_err<=1.
  - wrap<=0.
- en=1, clr=0, load=0, up_dn=1:
  - count==MODULUS-1: count<=0; wrap<=1.
  - otherwise: count<=count+1; wrap<=0.
- en=1, clr=0, load=0, up_dn=0:
  - count==0: count<=MODULUS-1; wrap<=1.
  - otherwise: count<=count-1; wrap<=0.
- en=0 with no clr or load: count holds; wrap<=0.
- tc is combinational: tc = en & (up_dn ? count==MODULUS-1 : count==0). tc is asserted in the same cycle the wrap will occur, so a downstream stage with en=tc increments on the same edge. Zero-latency cascade.
- wrap is registered: high for exactly one cycle after the edge that wrapped, low otherwise.
- load_err is sticky. It is cleared only by rst_n.
- Changing up_dn mid-count takes effect on the next enabled edge; no glitch in count.
- Arithmetic is performed in WIDTH+1 bits internally. count never leaves 0..MODULUS-1, including when MODULUS==2**WIDTH.
- Latency: 1 cycle from any control input to count. 0 cycles from count/en/up_dn to tc.
- Elaboration fails (assertion) if MODULUS<2, MODULUS>2**WIDTH, or RESET_VAL>=MODULUS.

Test Plan:
- Reset: WIDTH=12, MODULUS=800. Hold rst_n=0 for 20 ns, assert rst_n mid-cycle while counting -> count=0, wrap=0, load_err=0 immediately, no wait for clk.
- Up wrap: en=1, up_dn=1 from 0 for 800 edges -> count 0..799; tc=1 only while count==799; count=0 and wrap=1 for one cycle after edge 800.
- Down wrap / direction change: load 3, up_dn=0 for 4 edges -> 2,1,0,799 with wrap pulse after 0->799. Flip up_dn=1 -> 0 next edge with wrap pulse.
- Priority: clr=1, load=1 (load_val=5) and en=1 on the same edge -> count=0. Then load=1, en=1 -> count=5. Then en=0 for 10 edges -> count stays 5.
- Out-of-range load: load_val=900 -> count=799, load_err=1. Subsequent clr -> count=0, load_err still 1. rst_n pulse -> load_err=0.
- Cascade: h (MODULUS=800) tc drives v (MODULUS=525) en, free-run 800*525 edges -> v increments only on h 799->0 edges. Both at 0 after 420000 edges; v wrap pulses once.
